// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS subset core sharing one memory port for fetch and data
// Optional retired-instruction counter: define MIPS_MC_PERF_EN.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rstb,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemWData,
  input  logic [31:0]   MemRData,
  input  logic          MemAck,
  output logic          Halted
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]   InstrRetired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_mdr;
  logic [31:0] r_regs [32];
  logic        r_run;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_simm;
  logic        w_rtype_ok;
  logic        w_supported;
  logic [31:0] w_alu;
  logic        w_mem_req;
  logic        w_mem_fire;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_rtype_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                      (w_funct == FN_OR)  || (w_funct == FN_SLT);
  assign w_supported = ((w_op == OP_RTYPE) && w_rtype_ok) || (w_op == OP_ADDI) ||
                       (w_op == OP_LW) || (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_J);

  // r_run holds the port idle until the first clock edge after reset release,
  // so the request never rises while reset is still asserted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  assign w_mem_req  = r_run && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign w_mem_fire = w_mem_req && MemAck;

  always_comb begin
    w_alu = '0;
    case (w_funct)
      FN_ADD:  w_alu = r_a + r_b;
      FN_SUB:  w_alu = r_a - r_b;
      FN_AND:  w_alu = r_a & r_b;
      FN_OR:   w_alu = r_a | r_b;
      FN_SLT:  w_alu = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    MemReq   = w_mem_req;
    MemWe    = 1'b0;
    MemAddr  = r_pc[AW-1:0];
    MemWData = r_b;
    Halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_mem_fire) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = w_supported ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (w_op)
          OP_LW, OP_SW:  w_next = S_MEM;
          OP_BEQ, OP_J:  w_next = S_FETCH;
          default:       w_next = S_WB;
        endcase
      end
      S_MEM: begin
        MemAddr = r_aluout[AW-1:0];
        MemWe   = (w_op == OP_SW);
        if (w_mem_fire) w_next = (w_op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_next = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_mem_fire) begin
            r_ir <= MemRData;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
        end
        S_EXEC: begin
          case (w_op)
            OP_RTYPE:            r_aluout <= w_alu;
            OP_ADDI, OP_LW, OP_SW: r_aluout <= r_a + w_simm;
            OP_BEQ: if (r_a == r_b) r_pc <= r_pc + (w_simm << 2);
            OP_J:                r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_mem_fire && (w_op == OP_LW)) r_mdr <= MemRData;
        end
        S_WB: begin
          // R0 is never written, which keeps it reading as zero
          case (w_op)
            OP_RTYPE: if (w_rd != 5'd0) r_regs[w_rd] <= r_aluout;
            OP_ADDI:  if (w_rt != 5'd0) r_regs[w_rt] <= r_aluout;
            OP_LW:    if (w_rt != 5'd0) r_regs[w_rt] <= r_mdr;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  logic [31:0] r_retired;

  // Only WB, EXEC (beq/j) and MEM (sw) ever return to FETCH, so any entry into
  // FETCH marks a retired instruction.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_retired <= '0;
    else if ((r_state != S_FETCH) && (w_next == S_FETCH)) r_retired <= r_retired + 32'd1;
  end

  assign InstrRetired = r_retired;
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - self-checking bench for mips_mc_core against an instruction-level model
// Checks InstrRetired when built with MIPS_MC_PERF_EN.
module tb_mips_mc_core;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        Halted;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] InstrRetired;
`endif

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(RPC), .AW(32)) dut (
    .clk(clk),
    .rstb(rstb),
    .MemReq(MemReq),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWData(MemWData),
    .MemRData(MemRData),
    .MemAck(MemAck),
    .Halted(Halted)
`ifdef MIPS_MC_PERF_EN
    ,
    .InstrRetired(InstrRetired)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [1024];
  logic [31:0] mm  [1024];
  logic [31:0] mr  [32];

  int          o_t [$];
  logic [31:0] o_a [$];
  logic        o_we[$];
  logic [31:0] o_wd[$];
  int          o_halt_t;
  int          o_req_after_halt;

  int          e_t [$];
  logic [31:0] e_a [$];
  logic        e_we[$];
  logic [31:0] e_wd[$];
  int          e_halt_t;
  int          e_retired;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    enc_r = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    enc_i = {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      mm[i]  = '0;
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[11:2]] = data;
    mm[addr[11:2]]  = data;
  endtask

  task automatic apply_reset();
    rstb   = 1'b0;
    MemAck = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
  endtask

  // Memory responder: each request is acked after w wait cycles; random acks while idle.
  task automatic run_dut(input int w, input int ncyc);
    int          first;
    int          waits;
    bit          in_req;
    logic [31:0] cur_a;
    logic [31:0] cur_wd;
    logic        cur_we;
    int          cur_t;
    o_t.delete(); o_a.delete(); o_we.delete(); o_wd.delete();
    o_halt_t = -1;
    o_req_after_halt = 0;
    first = -1;
    waits = 0;
    in_req = 1'b0;
    cur_a = '0; cur_wd = '0; cur_we = 1'b0; cur_t = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (Halted && o_halt_t < 0 && first >= 0) o_halt_t = c - first;
      if (MemReq) begin
        if (o_halt_t >= 0) o_req_after_halt++;
        if (!in_req) begin
          in_req = 1'b1;
          waits  = 0;
          if (first < 0) first = c;
          cur_t = c - first; cur_a = MemAddr; cur_we = MemWe; cur_wd = MemWData;
        end else begin
          n_cmp++;
          if (MemAddr !== cur_a || MemWe !== cur_we || (cur_we && MemWData !== cur_wd)) begin
            n_fail++;
            $display("FAIL req_stable: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                     MemAddr, MemWe, MemWData, cur_a, cur_we, cur_wd);
          end
        end
        if (waits == w) begin
          MemAck   = 1'b1;
          MemRData = mem[cur_a[11:2]];
          if (cur_we) mem[cur_a[11:2]] = cur_wd;
          o_t.push_back(cur_t); o_a.push_back(cur_a); o_we.push_back(cur_we); o_wd.push_back(cur_wd);
          in_req = 1'b0;
        end else begin
          MemAck   = 1'b0;
          MemRData = $urandom;
          waits++;
        end
      end else begin
        MemAck   = 1'($urandom_range(0, 1));
        MemRData = $urandom;
      end
    end
    @(negedge clk);
    MemAck = 1'b0;
  endtask

  // Instruction-level reference: executes the program and lists every memory
  // access with its start cycle under a fixed per-access wait count w.
  task automatic run_model(input int w, input int max_instr);
    logic [31:0] pc, ir, a, b, v, simm, addr;
    logic [5:0]  op, fn;
    int          t;
    e_t.delete(); e_a.delete(); e_we.delete(); e_wd.delete();
    for (int i = 0; i < 32; i++) mr[i] = '0;
    e_halt_t  = -1;
    e_retired = 0;
    t  = 0;
    pc = RPC;
    for (int n = 0; n < max_instr; n++) begin
      ir = mm[pc[11:2]];
      e_t.push_back(t); e_a.push_back(pc); e_we.push_back(1'b0); e_wd.push_back('0);
      pc   = pc + 4;
      op   = ir[31:26];
      fn   = ir[5:0];
      a    = mr[ir[25:21]];
      b    = mr[ir[20:16]];
      simm = {{16{ir[15]}}, ir[15:0]};
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
        case (fn)
          6'h20:   v = a + b;
          6'h22:   v = a - b;
          6'h24:   v = a & b;
          6'h25:   v = a | b;
          default: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        if (ir[15:11] != 0) mr[ir[15:11]] = v;
        t += 4 + w;
      end else if (op == 6'h08) begin
        if (ir[20:16] != 0) mr[ir[20:16]] = a + simm;
        t += 4 + w;
      end else if (op == 6'h23) begin
        addr = a + simm;
        e_t.push_back(t + w + 3); e_a.push_back(addr); e_we.push_back(1'b0); e_wd.push_back('0);
        if (ir[20:16] != 0) mr[ir[20:16]] = mm[addr[11:2]];
        t += 5 + 2 * w;
      end else if (op == 6'h2B) begin
        addr = a + simm;
        e_t.push_back(t + w + 3); e_a.push_back(addr); e_we.push_back(1'b1); e_wd.push_back(b);
        mm[addr[11:2]] = b;
        t += 4 + 2 * w;
      end else if (op == 6'h04) begin
        if (a == b) pc = pc + (simm << 2);
        t += 3 + w;
      end else if (op == 6'h02) begin
        pc = {pc[31:28], ir[25:0], 2'b00};
        t += 3 + w;
      end else begin
        e_halt_t = t + w + 2;
        break;
      end
      e_retired++;
    end
  endtask

  task automatic test_reset();
    int k;
    clear_mem();
    put(RPC, 32'hFC00_0000);
    rstb   = 1'b0;
    MemAck = 1'b1;
    #1;
    n_cmp++;
    if (MemReq !== 1'b0 || MemWe !== 1'b0 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b halted=%b expected 0 0 0", MemReq, MemWe, Halted);
    end
`ifdef MIPS_MC_PERF_EN
    n_cmp++;
    if (InstrRetired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d expected 0", InstrRetired);
    end
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if (MemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_held: got %b expected 0", MemReq);
    end
    rstb   = 1'b1;
    MemAck = 1'b0;
    k = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (MemReq && k < 0) k = i;
    end
    n_cmp++;
    if (k != 0) begin
      n_fail++;
      $display("FAIL first_fetch_cycle: got %0d expected 0", k);
    end
    n_cmp++;
    if (MemAddr !== RPC || MemWe !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch_addr: got addr=%h we=%b expected addr=%h we=0", MemAddr, MemWe, RPC);
    end
  endtask

  task automatic test_reset_mid_request();
    clear_mem();
    put(RPC, 32'hFC00_0000);
    apply_reset();
    run_dut(10, 3);
    #2 rstb = 1'b0;
    #1;
    n_cmp++;
    if (MemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_req: got %b expected 0", MemReq);
    end
    MemAck   = 1'b1;
    MemRData = enc_r(0, 0, 1, 6'h20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstb   = 1'b1;
    MemAck = 1'b0;
    run_dut(0, 10);
    n_cmp++;
    if (o_a.size() < 1 || o_a[0] !== RPC) begin
      n_fail++;
      $display("FAIL restart_fetch: got %h expected %h", (o_a.size() > 0) ? o_a[0] : 32'hx, RPC);
    end
    n_cmp++;
    if (o_halt_t != 2) begin
      n_fail++;
      $display("FAIL restart_halt_t: got %0d expected 2", o_halt_t);
    end
  endtask

  task automatic test_alu_store();
    clear_mem();
    put(RPC + 0,  enc_i(6'h08, 0, 1, 16'd5));
    put(RPC + 4,  enc_i(6'h08, 0, 2, 16'd7));
    put(RPC + 8,  enc_r(1, 2, 3, 6'h20));
    put(RPC + 12, enc_i(6'h2B, 0, 3, 16'h0040));
    put(RPC + 16, 32'hFC00_0000);
    apply_reset();
    run_dut(0, 60);
    n_cmp++;
    if (o_a.size() != 6) begin
      n_fail++;
      $display("FAIL store_count: got %0d expected 6", o_a.size());
    end else begin
      n_cmp++;
      if (o_t[3] != 12 || o_a[3] !== RPC + 12) begin
        n_fail++;
        $display("FAIL sw_fetch: got t=%0d addr=%h expected t=12 addr=%h", o_t[3], o_a[3], RPC + 12);
      end
      n_cmp++;
      if (o_t[4] != 15 || o_a[4] !== 32'h40 || o_we[4] !== 1'b1 || o_wd[4] !== 32'd12) begin
        n_fail++;
        $display("FAIL sw_write: got t=%0d addr=%h we=%b wd=%0d expected t=15 addr=40 we=1 wd=12",
                 o_t[4], o_a[4], o_we[4], o_wd[4]);
      end
    end
    n_cmp++;
    if (o_halt_t != 18 || Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL store_halt: got t=%0d halted=%b expected t=18 halted=1", o_halt_t, Halted);
    end
`ifdef MIPS_MC_PERF_EN
    n_cmp++;
    if (InstrRetired !== 32'd4) begin
      n_fail++;
      $display("FAIL retired_frozen: got %0d expected 4", InstrRetired);
    end
`endif
  endtask

  task automatic test_load_wait();
    clear_mem();
    put(32'h40, 32'd12);
    put(RPC + 0, enc_i(6'h23, 0, 4, 16'h0040));
    put(RPC + 4, enc_i(6'h2B, 0, 4, 16'h0044));
    put(RPC + 8, 32'hFC00_0000);
    apply_reset();
    run_dut(3, 50);
    n_cmp++;
    if (o_a.size() != 5) begin
      n_fail++;
      $display("FAIL load_count: got %0d expected 5", o_a.size());
    end else begin
      n_cmp++;
      if (o_t[1] != 6 || o_a[1] !== 32'h40 || o_we[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_read: got t=%0d addr=%h we=%b expected t=6 addr=40 we=0", o_t[1], o_a[1], o_we[1]);
      end
      n_cmp++;
      if (o_t[2] != 11) begin
        n_fail++;
        $display("FAIL lw_cycles: got %0d expected 11", o_t[2]);
      end
      n_cmp++;
      if (o_a[3] !== 32'h44 || o_wd[3] !== 32'd12) begin
        n_fail++;
        $display("FAIL lw_result: got addr=%h wd=%0d expected addr=44 wd=12", o_a[3], o_wd[3]);
      end
    end
    n_cmp++;
    if (o_halt_t != 26) begin
      n_fail++;
      $display("FAIL load_halt: got %0d expected 26", o_halt_t);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    put(RPC, 32'h0800_0000);
    put(32'h0, enc_i(6'h04, 1, 1, 16'hFFFF));
    apply_reset();
    run_dut(0, 20);
    n_cmp++;
    if (o_a.size() < 5) begin
      n_fail++;
      $display("FAIL beq_count: got %0d expected >=5", o_a.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (o_a[i] !== 32'h0 || o_t[i] != 3 * i) begin
          n_fail++;
          $display("FAIL beq_loop[%0d]: got addr=%h t=%0d expected addr=0 t=%0d", i, o_a[i], o_t[i], 3 * i);
        end
      end
    end
  endtask

  task automatic test_jump();
    clear_mem();
    put(RPC, 32'h0800_0001);
    put(32'h4, 32'h0800_0010);
    put(32'h40, 32'hFC00_0000);
    apply_reset();
    run_dut(0, 20);
    n_cmp++;
    if (o_a.size() != 3) begin
      n_fail++;
      $display("FAIL jump_count: got %0d expected 3", o_a.size());
    end else begin
      n_cmp++;
      if (o_a[1] !== 32'h4 || o_a[2] !== 32'h40 || o_t[2] != 6) begin
        n_fail++;
        $display("FAIL jump_target: got %h %h t=%0d expected 4 40 t=6", o_a[1], o_a[2], o_t[2]);
      end
    end
    n_cmp++;
    if (o_halt_t != 8) begin
      n_fail++;
      $display("FAIL jump_halt: got %0d expected 8", o_halt_t);
    end
  endtask

  task automatic test_halt();
    clear_mem();
    put(RPC, 32'hFC00_0000);
    apply_reset();
    run_dut(2, 30);
    n_cmp++;
    if (o_halt_t != 4 || Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_time: got t=%0d halted=%b expected t=4 halted=1", o_halt_t, Halted);
    end
    n_cmp++;
    if (o_req_after_halt != 0 || o_a.size() != 1) begin
      n_fail++;
      $display("FAIL halt_quiet: got reqs=%0d fetches=%0d expected 0 and 1", o_req_after_halt, o_a.size());
    end
    put(RPC, enc_r(1, 2, 3, 6'h21));
    apply_reset();
    run_dut(0, 10);
    n_cmp++;
    if (o_a.size() != 1 || o_a[0] !== RPC || o_halt_t != 2) begin
      n_fail++;
      $display("FAIL bad_funct_halt: got fetches=%0d t=%0d expected 1 fetch at %h, t=2", o_a.size(), o_halt_t, RPC);
    end
  endtask

  task automatic test_random();
    logic [5:0]  fns [5];
    logic [31:0] pc;
    int          w;
    int          kind;
    int          ncmp_sz;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int it = 0; it < 6; it++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) put(32'h800 + 4 * i, $urandom);
      pc = RPC;
      for (int i = 0; i < 16; i++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: put(pc, enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fns[$urandom_range(0, 4)]));
          1: put(pc, enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
          2: put(pc, enc_i(6'h23, 0, $urandom_range(0, 7), 16'(32'h800 + 4 * $urandom_range(0, 63))));
          default: put(pc, enc_i(6'h2B, 0, $urandom_range(0, 7), 16'(32'h800 + 4 * $urandom_range(0, 63))));
        endcase
        pc = pc + 4;
      end
      for (int r = 1; r < 8; r++) begin
        put(pc, enc_i(6'h2B, 0, r, 16'(32'h900 + 4 * r)));
        pc = pc + 4;
      end
      put(pc, 32'hFC00_0000);
      w = $urandom_range(0, 3);
      run_model(w, 200);
      apply_reset();
      run_dut(w, e_halt_t + 25);
      n_cmp++;
      if (o_a.size() != e_a.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d expected %0d", it, o_a.size(), e_a.size());
      end
      ncmp_sz = (o_a.size() < e_a.size()) ? o_a.size() : e_a.size();
      for (int i = 0; i < ncmp_sz; i++) begin
        n_cmp++;
        if (o_t[i] != e_t[i] || o_a[i] !== e_a[i] || o_we[i] !== e_we[i] || (e_we[i] && o_wd[i] !== e_wd[i])) begin
          n_fail++;
          $display("FAIL rand%0d_access[%0d]: got t=%0d a=%h we=%b wd=%h expected t=%0d a=%h we=%b wd=%h",
                   it, i, o_t[i], o_a[i], o_we[i], o_wd[i], e_t[i], e_a[i], e_we[i], e_wd[i]);
        end
      end
      n_cmp++;
      if (o_halt_t != e_halt_t || o_req_after_halt != 0) begin
        n_fail++;
        $display("FAIL rand%0d_halt: got t=%0d reqs=%0d expected t=%0d reqs=0", it, o_halt_t, o_req_after_halt, e_halt_t);
      end
`ifdef MIPS_MC_PERF_EN
      n_cmp++;
      if (InstrRetired !== 32'(e_retired)) begin
        n_fail++;
        $display("FAIL rand%0d_retired: got %0d expected %0d", it, InstrRetired, e_retired);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_request();
    test_alu_store();
    test_load_wait();
    test_branch();
    test_jump();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
